// File: rtl/mips_fetch_if.sv
// rtl/mips_fetch_if.sv - fetch-stage bus: imem req/ack, decoder valid/ready, redirect/except
interface mips_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        except;
    logic        halted;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct, halted,
        input  imem_ack, imem_rdata, redirect, redirect_pc, inst_ready, except
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, opcode, funct, halted,
        output imem_ack, imem_rdata, redirect, redirect_pc, inst_ready, except
    );
endinterface

// File: rtl/mips_fetch.sv
// rtl/mips_fetch.sv - MIPS instruction fetch: PC, imem req/ack, instruction buffer, redirect/halt
module mips_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clock,
    input  logic         reset,
    mips_fetch_if.master bus
);
    localparam int           AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]  FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [31:0]     pc;
    logic [31:0]     req_addr;
    logic            outstanding;
    logic [31:0]     redirect_target;

    logic [31:0]     buf_inst [DEPTH];
    logic [31:0]     buf_pc   [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;

    logic            empty;
    logic            issue;
    logic            resp;
    logic            push;
    logic            pop;
    logic            exc_take;
    logic            flush;

    assign redirect_target = bus.redirect_pc & ~32'd3;
    assign empty           = (count == '0);

    // Redirect outranks the exception, so an except in a redirect cycle is ignored.
    assign exc_take = bus.inst_valid && bus.inst_ready && bus.except && !bus.redirect;
    assign flush    = bus.redirect || exc_take;

    // Credit rule: a new request only when nothing is in flight and a slot is free,
    // so the response can always be pushed. No new request starts in a flush cycle,
    // because a raised request can never be withdrawn.
    assign issue = !reset && (state == RUN) && !outstanding && (count < FULL)
                   && !bus.redirect && !exc_take;

    assign bus.imem_req  = outstanding || issue;
    assign bus.imem_addr = outstanding ? req_addr : pc;

    assign resp = bus.imem_req && bus.imem_ack;
    assign push = resp && (state == RUN) && !bus.redirect && !exc_take;
    assign pop  = bus.inst_valid && bus.inst_ready && !bus.except && !bus.redirect;

    assign bus.inst_valid = !empty;
    assign bus.halted     = (state == HALTED);
    assign bus.inst       = empty ? 32'd0 : buf_inst[rd_ptr];
    assign bus.inst_pc    = empty ? 32'd0 : buf_pc[rd_ptr];
    assign bus.opcode     = bus.inst[31:26];
    assign bus.funct      = bus.inst[5:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.redirect) begin
            // A request still in flight after this cycle must have its data discarded.
            state_next = (outstanding && !bus.imem_ack) ? DRAIN : RUN;
        end else if (exc_take) begin
            state_next = HALTED;
        end else if ((state == DRAIN) && resp) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc          <= RESET_PC;
            req_addr    <= RESET_PC;
            outstanding <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            outstanding <= bus.imem_req && !bus.imem_ack;
            if (issue) begin
                req_addr <= pc;
            end
            if (bus.redirect) begin
                pc <= redirect_target;
            end else if (push) begin
                pc <= pc + 32'd4;
            end
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            buf_inst[wr_ptr] <= bus.imem_rdata;
            buf_pc[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_mips_fetch.sv
// tb/tb_mips_fetch.sv - scoreboard testbench for mips_fetch
module tb_mips_fetch;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          DEPTH    = 2;

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } entry_t;

    logic clk = 1'b0;
    logic reset = 1'b0;

    mips_fetch_if bus();

    mips_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    entry_t      q[$];
    logic [31:0] model_pc = RESET_PC;
    logic [31:0] held_addr = '0;
    bit          req_seen = 0;
    bit          m_drop = 0;
    bit          m_halted = 0;
    int          wait_cnt = 0;
    int          latency = 1;
    int          mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        if (mode == 0) return 32'h0000_0020;
        return {addr[7:2], 20'h2a5c3, addr[7:2]};
    endfunction

    // One cycle: inputs were set at the negedge; check, answer memory, advance the model.
    task automatic step();
        bit     ack;
        bit     exc;
        bit     pop;
        bit     exp_req;
        entry_t e;
        #1;
        exc = (q.size() != 0) && bus.inst_ready && bus.except && !bus.redirect;
        pop = (q.size() != 0) && bus.inst_ready && !bus.except && !bus.redirect;
        exp_req = req_seen || (!m_halted && (q.size() < DEPTH) && !bus.redirect && !exc);
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        check("inst_valid", {31'd0, bus.inst_valid}, {31'd0, q.size() != 0});
        check("halted", {31'd0, bus.halted}, {31'd0, m_halted});
        if (q.size() != 0) begin
            e = q[0];
            check("inst", bus.inst, e.word);
            check("inst_pc", bus.inst_pc, e.pc);
            check("opcode", {26'd0, bus.opcode}, {26'd0, e.word[31:26]});
            check("funct", {26'd0, bus.funct}, {26'd0, e.word[5:0]});
        end
        if (pop) void'(q.pop_front());
        ack = 0;
        if (bus.imem_req) begin
            if (!req_seen) begin
                req_seen  = 1;
                wait_cnt  = 0;
                held_addr = model_pc;
                check("imem_addr", bus.imem_addr, model_pc);
            end else begin
                wait_cnt++;
                check("addr_hold", bus.imem_addr, held_addr);
            end
            if (wait_cnt >= latency) ack = 1;
        end
        bus.imem_ack   = ack;
        bus.imem_rdata = ack ? mem_word(held_addr) : 32'hdead_beef;
        if (bus.redirect) begin
            q.delete();
            m_drop   = req_seen && !ack;
            model_pc = bus.redirect_pc & ~32'd3;
            m_halted = 0;
        end else if (exc) begin
            q.delete();
            m_halted = 1;
        end else if (ack) begin
            if (!m_drop && !m_halted) begin
                e.word = mem_word(held_addr);
                e.pc   = held_addr;
                q.push_back(e);
                model_pc = model_pc + 32'd4;
            end
            m_drop = 0;
        end
        if (ack) req_seen = 0;
        @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input bit ack_now);
        reset        = 1'b1;
        bus.redirect = 1'b0;
        bus.except   = 1'b0;
        if (ack_now && req_seen) begin
            bus.imem_ack   = 1'b1;
            bus.imem_rdata = mem_word(held_addr);
        end
        @(posedge clk);
        @(negedge clk);
        bus.imem_ack = 1'b0;
        #1;
        check("rst_req", {31'd0, bus.imem_req}, 32'd0);
        check("rst_valid", {31'd0, bus.inst_valid}, 32'd0);
        check("rst_halted", {31'd0, bus.halted}, 32'd0);
        check("rst_inst", bus.inst, 32'd0);
        check("rst_inst_pc", bus.inst_pc, 32'd0);
        check("rst_opcode", {26'd0, bus.opcode}, 32'd0);
        check("rst_funct", {26'd0, bus.funct}, 32'd0);
        reset = 1'b0;
        q.delete();
        model_pc = RESET_PC;
        req_seen = 0;
        m_drop   = 0;
        m_halted = 0;
        wait_cnt = 0;
    endtask

    task automatic wait_req(input logic [31:0] addr, input string tag);
        bit found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (req_seen && held_addr == addr) found = 1;
            else step();
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        bit found;
        int guard;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        bus.except      = 1'b0;

        // Streaming add instructions, one-cycle memory.
        do_reset(0);
        mode = 0; latency = 1; bus.inst_ready = 1'b1;
        run(14);

        // Decoder stalled: exactly DEPTH fetches, then resume in order.
        do_reset(0);
        mode = 1; bus.inst_ready = 1'b0;
        run(8);
        #1;
        check("full_noreq", {31'd0, bus.imem_req}, 32'd0);
        check("full_valid", {31'd0, bus.inst_valid}, 32'd1);
        bus.inst_ready = 1'b1;
        wait_req(32'h0040_0008, "resume_0008");
        run(6);

        // Slow memory: ack held low five cycles.
        latency = 5;
        run(20);

        // Redirect while the request to 0x00400008 is pending.
        do_reset(0);
        latency = 3;
        wait_req(32'h0040_0008, "pending_0008");
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_0103;
        step();
        bus.redirect = 1'b0;
        check("redir_empty", {31'd0, bus.inst_valid}, 32'd0);
        wait_req(32'h0040_0100, "redir_fetch");
        run(10);

        // Exception halts fetch; redirect to the handler restarts it.
        do_reset(0);
        latency = 1; mode = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.inst_valid) found = 1;
            else step();
        end
        check("exc_head", {31'd0, found}, 32'd1);
        bus.except = 1'b1;
        step();
        bus.except = 1'b0;
        check("exc_halted", {31'd0, bus.halted}, 32'd1);
        run(6);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_0180;
        step();
        bus.redirect = 1'b0;
        check("handler_unhalt", {31'd0, bus.halted}, 32'd0);
        wait_req(32'h8000_0180, "handler_fetch");
        run(10);

        // Reset during DRAIN, coinciding with the drained ack.
        do_reset(0);
        latency = 3;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (req_seen) found = 1;
            else step();
        end
        check("drain_req", {31'd0, found}, 32'd1);
        bus.redirect = 1'b1; bus.redirect_pc = 32'h0040_0200;
        step();
        bus.redirect = 1'b0;
        guard = 0;
        while (req_seen && wait_cnt + 1 < latency && guard < 10) begin
            step();
            guard++;
        end
        check("drain_pending", {31'd0, req_seen}, 32'd1);
        do_reset(1);
        wait_req(RESET_PC, "post_reset_fetch");
        run(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
